// File: rtl/obu_parse_sequencer.sv
// -----------------------------------------------------------------------------
// obu_parse_sequencer
//
// Top-level sequencer for the OBU parsing pipeline. Runs the OBU header
// parser, latches the decoded type and payload size, then either hands the
// payload to one of three payload parsers (sequence header, frame header,
// tile group) or discards it with an internal byte-skip engine. The single
// bitstream word buffer is shared; this block multiplexes its pop/pad
// controls so only the active stage can drive it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                level; while high, OBUs are parsed back-to-back
//   stream_valid          buffer holds a valid head word
//   stream_pop/pad/_len   buffer controls (pad length in bits, multiple of 8)
//   hdr_start             one-cycle start pulse to the header parser
//   hdr_done/pop/pad/...  header parser handshake, buffer requests, results
//   pl_start[2:0]         one-hot start: 0 seq header, 1 frame header, 2 tile group
//   pl_done/pop/pad/...   payload parser handshakes; pl_pad_len slice i = parser i
//   busy                  sequencer is not idle
//   cur_obu_type          latched type of the OBU in progress
//   obu_count             OBUs completed (parsed or skipped), wrapping
//   error                 sticky watchdog flag, cleared by dropping enable
// -----------------------------------------------------------------------------
module obu_parse_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            stream_valid,
  output logic                            stream_pop,
  output logic                            stream_pad,
  output logic [$clog2(DATA_WIDTH)-1:0]   stream_pad_len,
  output logic                            hdr_start,
  input  logic                            hdr_done,
  input  logic                            hdr_pop,
  input  logic                            hdr_pad,
  input  logic [$clog2(DATA_WIDTH)-1:0]   hdr_pad_len,
  input  logic [3:0]                      hdr_obu_type,
  input  logic [31:0]                     hdr_obu_size,
  output logic [2:0]                      pl_start,
  input  logic [2:0]                      pl_done,
  input  logic [2:0]                      pl_pop,
  input  logic [2:0]                      pl_pad,
  input  logic [3*$clog2(DATA_WIDTH)-1:0] pl_pad_len,
  output logic                            busy,
  output logic [3:0]                      cur_obu_type,
  output logic [15:0]                     obu_count,
  output logic                            error
);

  localparam int          PW      = $clog2(DATA_WIDTH);
  localparam logic [31:0] BPW     = 32'(DATA_WIDTH / 8);  // bytes per word
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_START,
    S_HDR_WAIT,
    S_DISPATCH,
    S_PL_WAIT,
    S_SKIP,
    S_ERR
  } state_t;

  state_t       state, state_nxt;
  logic [31:0]  remaining;   // payload bytes still to be consumed
  logic [31:0]  wdog;        // cycles spent in the current state
  logic [1:0]   sel;         // payload parser index chosen in DISPATCH

  logic         tgt_valid;
  logic [1:0]   tgt;
  logic         sel_done, sel_pop, sel_pad;
  logic [PW-1:0] sel_len;
  logic         skip_pop, skip_pad;
  logic [PW-1:0] skip_len;
  logic         wd_active, wd_expired, obu_done;
  logic         src_pop, src_pad;
  logic [PW-1:0] src_len;

  // Payload parser selection from the latched OBU type.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so a
    // missed case branch cannot infer a latch.
    tgt_valid = 1'b1;
    tgt       = 2'd0;
    case (cur_obu_type)
      4'd1:              tgt = 2'd0;
      4'd3, 4'd6, 4'd7:  tgt = 2'd1;
      4'd4:              tgt = 2'd2;
      default:           tgt_valid = 1'b0;
    endcase
  end

  // Handshake and buffer requests of the selected payload parser.
  always_comb begin
    sel_done = 1'b0;
    sel_pop  = 1'b0;
    sel_pad  = 1'b0;
    sel_len  = '0;
    case (sel)
      2'd0: begin
        sel_done = pl_done[0];
        sel_pop  = pl_pop[0];
        sel_pad  = pl_pad[0];
        sel_len  = pl_pad_len[PW-1:0];
      end
      2'd1: begin
        sel_done = pl_done[1];
        sel_pop  = pl_pop[1];
        sel_pad  = pl_pad[1];
        sel_len  = pl_pad_len[2*PW-1:PW];
      end
      2'd2: begin
        sel_done = pl_done[2];
        sel_pop  = pl_pop[2];
        sel_pad  = pl_pad[2];
        sel_len  = pl_pad_len[3*PW-1:2*PW];
      end
      default: ;
    endcase
  end

  // Skip engine: whole words while at least one word of payload remains,
  // then a single pad of the byte remainder. remaining < BPW whenever a pad
  // is issued, so remaining*8 always fits the pad length field.
  assign skip_pop = (state == S_SKIP) && stream_valid && (remaining >= BPW);
  assign skip_pad = (state == S_SKIP) && stream_valid && (remaining <  BPW);
  assign skip_len = PW'(remaining << 3);

  assign wd_active  = (state == S_HDR_WAIT) || (state == S_PL_WAIT) || (state == S_SKIP);
  assign wd_expired = (wdog == WD_LAST);

  // Next-state logic. A done in the expiry cycle takes priority over ERR.
  always_comb begin
    state_nxt = state;
    obu_done  = 1'b0;
    case (state)
      S_IDLE:      if (enable) state_nxt = S_HDR_START;
      S_HDR_START: state_nxt = S_HDR_WAIT;
      S_HDR_WAIT: begin
        if (hdr_done)        state_nxt = S_DISPATCH;
        else if (wd_expired) state_nxt = S_ERR;
      end
      S_DISPATCH: begin
        if (tgt_valid)             state_nxt = S_PL_WAIT;
        else if (remaining != '0)  state_nxt = S_SKIP;
        else                       obu_done  = 1'b1;
      end
      S_PL_WAIT: begin
        if (sel_done)        obu_done  = 1'b1;
        else if (wd_expired) state_nxt = S_ERR;
      end
      S_SKIP: begin
        if ((skip_pop && remaining == BPW) || skip_pad) obu_done  = 1'b1;
        else if (wd_expired)                            state_nxt = S_ERR;
      end
      S_ERR:       if (!enable) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (obu_done) state_nxt = enable ? S_HDR_START : S_IDLE;
  end

  // Buffer control mux, combinational from the state register so the active
  // stage's requests reach the buffer with no added latency.
  always_comb begin
    src_pop = 1'b0;
    src_pad = 1'b0;
    src_len = '0;
    case (state)
      S_HDR_WAIT: begin
        src_pop = hdr_pop;
        src_pad = hdr_pad;
        src_len = hdr_pad_len;
      end
      S_PL_WAIT: begin
        src_pop = sel_pop;
        src_pad = sel_pad;
        src_len = sel_len;
      end
      S_SKIP: begin
        src_pop = skip_pop;
        src_pad = skip_pad;
        src_len = skip_len;
      end
      default: ;
    endcase
  end

  // Pop wins over pad; the pad length is only meaningful alongside pad.
  assign stream_pop     = src_pop;
  assign stream_pad     = src_pad & ~src_pop;
  assign stream_pad_len = stream_pad ? src_len : '0;
  assign busy           = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      wdog         <= '0;
      sel          <= '0;
      cur_obu_type <= '0;
      obu_count    <= '0;
      error        <= 1'b0;
      hdr_start    <= 1'b0;
      pl_start     <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register here samples the pre-edge values, matching the hardware.
      state <= state_nxt;

      if (state_nxt != state) wdog <= '0;
      else if (wd_active)     wdog <= wdog + 32'd1;

      if (state == S_HDR_WAIT && hdr_done) begin
        cur_obu_type <= hdr_obu_type;
        remaining    <= hdr_obu_size;
      end else if (skip_pop) begin
        remaining <= remaining - BPW;
      end else if (skip_pad) begin
        remaining <= '0;
      end

      if (state == S_DISPATCH) sel <= tgt;
      if (obu_done)            obu_count <= obu_count + 16'd1;

      // Starts are registered one-cycle pulses issued on leaving the
      // launching state.
      hdr_start <= (state == S_HDR_START);
      pl_start  <= (state == S_DISPATCH && tgt_valid) ? (3'b001 << tgt) : 3'b000;
      error     <= (state_nxt == S_ERR);
    end
  end

endmodule
